// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: pops one LFSR-chosen mole at a time,
// scores hits, derives difficulty and counts down the round timer.
module mole_game_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned GAME_SEC  = 60,
  parameter int unsigned GAP_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] bt_hit,
  output logic [2:0] mole_en,
  output logic [9:0] score,
  output logic [1:0] level,
  output logic [6:0] timer,
  output logic       hit_music,
  output logic       game_over
);

  localparam int unsigned TICK_CYC = (CLK_HZ / 10 > 0) ? CLK_HZ / 10 : 1;
  localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

  state_t        r_state,     w_state;
  logic [7:0]    r_lfsr,      w_lfsr;
  logic [PW-1:0] r_presc,     w_presc;
  logic [3:0]    r_tenth,     w_tenth;
  logic [7:0]    r_phase,     w_phase;
  logic [2:0]    r_mole_en,   w_mole_en;
  logic [9:0]    r_score,     w_score;
  logic [1:0]    r_level,     w_level;
  logic [6:0]    r_timer,     w_timer;
  logic          r_hit_music, w_hit_music;

  logic          w_run, w_tick, w_sec, w_phase_end, w_hit;
  logic [9:0]    w_score_inc;
  logic [1:0]    w_pick;

  function automatic logic [7:0] up_ticks(input logic [1:0] lv);
    case (lv)
      2'd0:    up_ticks = 8'd10;
      2'd1:    up_ticks = 8'd7;
      2'd2:    up_ticks = 8'd5;
      default: up_ticks = 8'd3;
    endcase
  endfunction

  function automatic logic [1:0] level_of(input logic [9:0] s);
    if (s >= 10'd30)      level_of = 2'd3;
    else if (s >= 10'd20) level_of = 2'd2;
    else if (s >= 10'd10) level_of = 2'd1;
    else                  level_of = 2'd0;
  endfunction

  always_comb begin
    w_lfsr      = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_state     = r_state;
    w_presc     = r_presc;
    w_tenth     = r_tenth;
    w_phase     = r_phase;
    w_mole_en   = r_mole_en;
    w_score     = r_score;
    w_level     = r_level;
    w_timer     = r_timer;
    w_hit_music = 1'b0;

    w_run       = (r_state == S_GAP) || (r_state == S_UP);
    w_tick      = w_run && (r_presc == PW'(TICK_CYC - 1));
    w_sec       = w_tick && (r_tenth == 4'd9);
    w_phase_end = w_tick && (r_phase <= 8'd1);
    w_hit       = (r_state == S_UP) && ((bt_hit & r_mole_en) != 3'b000);
    w_score_inc = (r_score >= 10'd999) ? r_score : r_score + 10'd1;
    w_pick      = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];

    if (start) begin
      w_state   = S_GAP;
      w_presc   = '0;
      w_tenth   = '0;
      w_phase   = 8'(GAP_TICKS);
      w_mole_en = '0;
      w_score   = '0;
      w_level   = '0;
      w_timer   = 7'(GAME_SEC);
    end else begin
      if (w_run) begin
        w_presc = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) w_tenth = (r_tenth == 4'd9) ? 4'd0 : r_tenth + 4'd1;
        if (w_tick && (r_phase != 8'd0)) w_phase = r_phase - 8'd1;
        if (w_sec) w_timer = r_timer - 7'd1;
      end

      case (r_state)
        S_GAP: begin
          if (w_phase_end) begin
            w_mole_en = 3'b001 << w_pick;
            w_phase   = up_ticks(r_level);
            w_state   = S_UP;
          end
        end
        S_UP: begin
          // a hit outranks a same-cycle expiry of the mole window
          if (w_hit) begin
            w_score     = w_score_inc;
            w_level     = level_of(w_score_inc);
            w_hit_music = 1'b1;
            w_mole_en   = '0;
            w_phase     = 8'(GAP_TICKS);
            w_state     = S_GAP;
          end else if (w_phase_end) begin
            w_mole_en = '0;
            w_phase   = 8'(GAP_TICKS);
            w_state   = S_GAP;
          end
        end
        default: ;
      endcase

      // round end overrides the mole decision but keeps any score update above
      if (w_sec && (r_timer <= 7'd1)) begin
        w_state   = S_OVER;
        w_mole_en = '0;
        w_timer   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 8'hA5;
      r_presc     <= '0;
      r_tenth     <= '0;
      r_phase     <= '0;
      r_mole_en   <= '0;
      r_score     <= '0;
      r_level     <= '0;
      r_timer     <= '0;
      r_hit_music <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lfsr      <= w_lfsr;
      r_presc     <= w_presc;
      r_tenth     <= w_tenth;
      r_phase     <= w_phase;
      r_mole_en   <= w_mole_en;
      r_score     <= w_score;
      r_level     <= w_level;
      r_timer     <= w_timer;
      r_hit_music <= w_hit_music;
    end
  end

  assign mole_en   = r_mole_en;
  assign score     = r_score;
  assign level     = r_level;
  assign timer     = r_timer;
  assign hit_music = r_hit_music;
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl at CLK_HZ=100 (tick = 10 cycles, second = 100 cycles).
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] bt_hit;
  logic [2:0] mole_en;
  logic [9:0] score;
  logic [1:0] level;
  logic [6:0] timer;
  logic       hit_music, game_over;

  logic       s_start;
  logic [2:0] s_bt, s_mole;
  logic [9:0] s_score;
  logic [1:0] s_level;
  logic [6:0] s_timer;
  logic       s_music, s_over;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int exp_score = 0;
  logic [7:0] m_lfsr, prev_lfsr;

  always #5 clk = ~clk;

  mole_game_ctrl #(.CLK_HZ(100), .GAME_SEC(60), .GAP_TICKS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bt_hit(bt_hit), .mole_en(mole_en),
    .score(score), .level(level), .timer(timer), .hit_music(hit_music),
    .game_over(game_over));

  // short gap and long round so the score can be driven to saturation in time
  mole_game_ctrl #(.CLK_HZ(100), .GAME_SEC(127), .GAP_TICKS(1)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .bt_hit(s_bt), .mole_en(s_mole),
    .score(s_score), .level(s_level), .timer(s_timer), .hit_music(s_music),
    .game_over(s_over));

  // reference mole-choice sequence: x^8+x^6+x^5+x^4+1 from seed A5
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [2:0] onehot(input logic [7:0] l);
    logic [1:0] b;
    b = l[1:0];
    if (b == 2'd3) b = 2'd1;
    return 3'b001 << b;
  endfunction

  function automatic int lvl(input int s);
    if (s >= 30) return 3;
    if (s >= 20) return 2;
    if (s >= 10) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    prev_lfsr = m_lfsr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc = 0;
    exp_score = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_mole(input int limit, output int n);
    n = 0;
    while (mole_en == 3'b000 && n < limit) begin
      step();
      n++;
    end
    chk("mole_pop", int'(mole_en), int'(onehot(prev_lfsr)));
  endtask

  // wrong-button press first (must be ignored), then the right one plus an extra bit
  task automatic do_hit();
    logic [2:0] mv, wrong;
    mv = mole_en;
    wrong = {mv[1:0], mv[2]};
    bt_hit = wrong;
    step();
    bt_hit = 3'b000;
    chk("wrong_btn_mole", int'(mole_en), int'(mv));
    chk("wrong_btn_score", int'(score), exp_score);
    chk("wrong_btn_music", int'(hit_music), 0);
    bt_hit = mv | wrong;
    step();
    bt_hit = 3'b000;
    exp_score = (exp_score >= 999) ? 999 : exp_score + 1;
    chk("hit_score", int'(score), exp_score);
    chk("hit_level", int'(level), lvl(exp_score));
    chk("hit_music", int'(hit_music), 1);
    chk("hit_retract", int'(mole_en), 0);
    step();
    chk("music_one_cycle", int'(hit_music), 0);
  endtask

  typedef struct {
    int unsigned at;
    logic        pop;
    logic        mole_on;
    int          tmr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [2:0] exp_m;
    logic all_on, any_music;
    int n;

    vt[0] = '{1,   1'b0, 1'b0, 60};
    vt[1] = '{30,  1'b0, 1'b0, 60};
    vt[2] = '{31,  1'b1, 1'b1, 60};
    vt[3] = '{100, 1'b0, 1'b1, 60};
    vt[4] = '{101, 1'b0, 1'b1, 59};
    vt[5] = '{130, 1'b0, 1'b1, 59};
    vt[6] = '{131, 1'b0, 1'b0, 59};
    vt[7] = '{161, 1'b1, 1'b1, 59};

    rst = 1'b0; start = 1'b0; bt_hit = 3'b000; s_start = 1'b0; s_bt = 3'b000;
    exp_m = 3'b000;
    step(); step();
    chk("rst_mole", int'(mole_en), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_timer", int'(timer), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_sat_score", int'(s_score), 0);
    rst = 1'b1;
    bt_hit = 3'b111;
    for (int i = 0; i < 20; i++) step();
    bt_hit = 3'b000;
    chk("idle_mole", int'(mole_en), 0);
    chk("idle_score", int'(score), 0);
    chk("idle_timer", int'(timer), 0);

    // first round, no hits: gap, pop, 100-cycle window, timer boundary
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      while (cyc < vt[i].at) step();
      if (vt[i].pop) exp_m = onehot(prev_lfsr);
      chk($sformatf("vec%0d_mole", i), int'(mole_en), vt[i].mole_on ? int'(exp_m) : 0);
      chk($sformatf("vec%0d_timer", i), int'(timer), vt[i].tmr);
      chk($sformatf("vec%0d_score", i), int'(score), 0);
      chk($sformatf("vec%0d_over", i), int'(game_over), 0);
    end

    // ten hits: score 1..10, level 1 at score 10, next pop 30 cycles after previous
    for (int h = 1; h <= 10; h++) begin
      if (h > 1) begin
        wait_mole(40, n);
        chk("gap_len", n, 27);
      end
      do_hit();
    end
    wait_mole(40, n);
    all_on = 1'b1;
    exp_m = mole_en;
    for (int i = 0; i < 69; i++) begin
      step();
      if (mole_en != exp_m) all_on = 1'b0;
    end
    chk("lvl1_window_held", int'(all_on), 1);
    step();
    chk("lvl1_window_end", int'(mole_en), 0);
    chk("lvl1_level", int'(level), 1);

    // round end with a hit on the final second boundary
    pulse_start();
    chk("restart_score", int'(score), 0);
    chk("restart_level", int'(level), 0);
    chk("restart_timer", int'(timer), 60);
    while (cyc < 31) step();
    chk("r2_pop", int'(mole_en), int'(onehot(prev_lfsr)));
    bt_hit = mole_en;
    step();
    bt_hit = 3'b000;
    chk("r2_hit_score", int'(score), 1);
    while (cyc < 6000) step();
    chk("pre_end_mole_up", int'(mole_en != 3'b000), 1);
    chk("pre_end_timer", int'(timer), 1);
    chk("pre_end_over", int'(game_over), 0);
    bt_hit = mole_en;
    step();
    bt_hit = 3'b000;
    chk("end_hit_score", int'(score), 2);
    chk("end_hit_music", int'(hit_music), 1);
    chk("end_mole", int'(mole_en), 0);
    chk("end_timer", int'(timer), 0);
    chk("end_over", int'(game_over), 1);
    any_music = 1'b0;
    bt_hit = 3'b111;
    for (int i = 0; i < 20; i++) begin
      step();
      if (hit_music) any_music = 1'b1;
    end
    bt_hit = 3'b000;
    chk("over_music", int'(any_music), 0);
    chk("over_score", int'(score), 2);
    chk("over_mole", int'(mole_en), 0);
    chk("over_held", int'(game_over), 1);
    pulse_start();
    chk("over_restart_score", int'(score), 0);
    chk("over_restart_timer", int'(timer), 60);
    chk("over_restart_over", int'(game_over), 0);

    // saturation on the second instance
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int k = 1; k <= 1003; k++) begin
      n = 0;
      while (s_mole == 3'b000 && n < 40) begin
        step();
        n++;
      end
      if (s_mole == 3'b000) begin
        chk("sat_pop_timeout", 0, 1);
        break;
      end
      s_bt = s_mole;
      step();
      s_bt = 3'b000;
      chk($sformatf("sat_score_%0d", k), int'(s_score), (k > 999) ? 999 : k);
      if (k >= 998) begin
        chk("sat_music", int'(s_music), 1);
        chk("sat_retract", int'(s_mole), 0);
      end
    end
    chk("sat_level", int'(s_level), 3);
    chk("sat_not_over", int'(s_over), 0);

    // async reset mid-UP, then start during UP
    pulse_start();
    wait_mole(40, n);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_mole", int'(mole_en), 0);
    chk("async_rst_timer", int'(timer), 0);
    chk("async_rst_over", int'(game_over), 0);
    chk("async_rst_sat_score", int'(s_score), 0);
    step(); step();
    rst = 1'b1;
    bt_hit = 3'b111;
    for (int i = 0; i < 50; i++) step();
    bt_hit = 3'b000;
    chk("post_rst_mole", int'(mole_en), 0);
    chk("post_rst_score", int'(score), 0);
    chk("post_rst_timer", int'(timer), 0);
    pulse_start();
    wait_mole(40, n);
    do_hit();
    wait_mole(40, n);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("up_start_mole", int'(mole_en), 0);
    chk("up_start_score", int'(score), 0);
    chk("up_start_timer", int'(timer), 60);
    chk("up_start_music", int'(hit_music), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
